// File: rtl/ctrl_pkg.sv
// ctrl_pkg: state encoding, opcode/ALU encodings and the decoded control word
// shared by the control sequencer and its instruction decoder.
package ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    // Major opcodes, instr[MCODEBITS-1 -: 3]
    localparam logic [2:0] OPC_ALU  = 3'b000;
    localparam logic [2:0] OPC_LD   = 3'b001;
    localparam logic [2:0] OPC_ST   = 3'b010;
    localparam logic [2:0] OPC_ADDI = 3'b011;
    localparam logic [2:0] OPC_BRZ  = 3'b100;
    localparam logic [2:0] OPC_MOV  = 3'b101;
    localparam logic [2:0] OPC_SHF  = 3'b110;
    localparam logic [2:0] OPC_LOG  = 3'b111;

    // Internal ALU operation codes; the sequencer widens them to OPWIDTH
    localparam int ALU_OPW = 4;
    localparam logic [ALU_OPW-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_OPW-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_OPW-1:0] ALU_LSL  = 4'd2;
    localparam logic [ALU_OPW-1:0] ALU_ASR  = 4'd3;
    localparam logic [ALU_OPW-1:0] ALU_LSR  = 4'd4;
    localparam logic [ALU_OPW-1:0] ALU_NOT  = 4'd5;
    localparam logic [ALU_OPW-1:0] ALU_AND  = 4'd6;
    localparam logic [ALU_OPW-1:0] ALU_OR   = 4'd7;
    localparam logic [ALU_OPW-1:0] ALU_MUL  = 4'd8;
    localparam logic [ALU_OPW-1:0] ALU_PASS = 4'hF;

    typedef struct packed {
        logic               reg_dst;
        logic               alu_src;
        logic               mem_to_reg;
        logic               mem_read;
        logic               mem_write;
        logic               reg_write;
        logic               branch;
        logic               mul;
        logic               halt;
        logic               illegal;
        logic [ALU_OPW-1:0] alu_op;
    } ctrl_word_t;

    // Control word that drives nothing: all selects low, ALU passing a through
    function automatic ctrl_word_t ctrl_idle();
        ctrl_word_t w;
        w        = '0;
        w.alu_op = ALU_PASS;
        return w;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: purely combinational opcode/funct decoder producing one
// ctrl_word_t per instruction. Only the opcode and funct fields take part
// in decoding; the operand fields travel through the datapath untouched.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int MCODEBITS = 9
) (
    input  logic [MCODEBITS-1:0] i_instr,
    output ctrl_word_t           o_ctrl
);

    logic [2:0] w_opc;
    logic [1:0] w_fn;
    ctrl_word_t w_c;

    assign w_opc  = i_instr[MCODEBITS-1 -: 3];
    assign w_fn   = i_instr[MCODEBITS-4 -: 2];
    assign o_ctrl = w_c;

    // Opcode/funct table; anything not listed decodes as illegal with no side effects
    always_comb begin
        w_c = ctrl_idle();
        case (w_opc)
            OPC_ALU: begin
                case (w_fn)
                    2'b00: begin
                        w_c.reg_dst   = 1'b1;
                        w_c.reg_write = 1'b1;
                        w_c.alu_op    = ALU_ADD;
                    end
                    2'b01: begin
                        w_c.reg_dst   = 1'b1;
                        w_c.reg_write = 1'b1;
                        w_c.alu_op    = ALU_SUB;
                    end
                    default: w_c.illegal = 1'b1;
                endcase
            end
            OPC_LD: begin
                w_c.mem_read   = 1'b1;
                w_c.mem_to_reg = 1'b1;
                w_c.reg_write  = 1'b1;
            end
            OPC_ST: begin
                w_c.mem_write = 1'b1;
            end
            OPC_ADDI: begin
                w_c.alu_src   = 1'b1;
                w_c.reg_write = 1'b1;
                w_c.alu_op    = ALU_ADD;
            end
            OPC_BRZ: begin
                w_c.branch = 1'b1;
            end
            OPC_MOV: begin
                if (w_fn == 2'b11) begin
                    w_c.halt = 1'b1;
                end else begin
                    w_c.reg_dst   = 1'b1;
                    w_c.reg_write = 1'b1;
                end
            end
            OPC_SHF: begin
                w_c.reg_dst   = 1'b1;
                w_c.reg_write = 1'b1;
                case (w_fn)
                    2'b00:   w_c.alu_op = ALU_LSL;
                    2'b01:   w_c.alu_op = ALU_ASR;
                    2'b10:   w_c.alu_op = ALU_LSR;
                    default: w_c.alu_op = ALU_NOT;
                endcase
            end
            OPC_LOG: begin
                case (w_fn)
                    2'b00: begin
                        w_c.reg_dst   = 1'b1;
                        w_c.reg_write = 1'b1;
                        w_c.alu_op    = ALU_AND;
                    end
                    2'b01: begin
                        w_c.reg_dst   = 1'b1;
                        w_c.reg_write = 1'b1;
                        w_c.alu_op    = ALU_OR;
                    end
                    2'b10: begin
                        w_c.reg_dst   = 1'b1;
                        w_c.reg_write = 1'b1;
                        w_c.mul       = 1'b1;
                        w_c.alu_op    = ALU_MUL;
                    end
                    default: w_c.illegal = 1'b1;
                endcase
            end
            default: w_c.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: multi-cycle FETCH->DECODE->EXEC->(MEM)->WB control sequencer
// with registered control outputs, multi-cycle MUL, memory wait states,
// conditional branch and a sticky HALT state.
// Optional build macro CTRL_ILLEGAL_TRAP_EN: adds output illegal_op and sends
// an illegal decode straight to HALT instead of retiring it as a NOP.
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int MCODEBITS  = 9,
    parameter int OPWIDTH    = 4,
    parameter int MUL_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [MCODEBITS-1:0] instr,
    input  logic                 zero_flag,
    input  logic                 mem_ack,
    output logic                 reg_dst,
    output logic                 alu_src,
    output logic                 mem_to_reg,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 reg_write,
    output logic                 pc_en,
    output logic                 branch_taken,
    output logic [OPWIDTH-1:0]   alu_op,
    output logic                 busy,
    output logic                 halted
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    output logic                 illegal_op
`endif
);

    // EXEC countdown: wide enough for MUL_CYCLES-1, at least one bit
    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);

    // Widen the internal ALU code; pass-through is all ones at any OPWIDTH
    function automatic logic [OPWIDTH-1:0] map_alu_op(input logic [ALU_OPW-1:0] code);
        if (code == ALU_PASS) begin
            return '1;
        end
        return OPWIDTH'(code);
    endfunction

    state_t               r_state;
    logic [MCODEBITS-1:0] r_instr;
    logic [CW-1:0]        r_cnt;
    logic                 r_zero;

    // Per-instruction bits remembered from DECODE for later states
    logic r_rd_op;
    logic r_wr_op;
    logic r_wb_op;
    logic r_br_op;
    logic r_halt_op;

    // Registered outputs
    logic               r_instr_ready;
    logic               r_reg_dst;
    logic               r_alu_src;
    logic               r_mem_to_reg;
    logic               r_mem_read;
    logic               r_mem_write;
    logic               r_reg_write;
    logic               r_pc_en;
    logic               r_branch_taken;
    logic [OPWIDTH-1:0] r_alu_op;
    logic               r_busy;
    logic               r_halted;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic               r_illegal_op;
`endif

    ctrl_word_t w_dec;
    logic       w_trap;

    ctrl_decode #(
        .MCODEBITS (MCODEBITS)
    ) u_decode (
        .i_instr (r_instr),
        .o_ctrl  (w_dec)
    );

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign w_trap = w_dec.illegal;
`else
    assign w_trap = 1'b0;
`endif

    // Instruction latch: captured only on the FETCH handshake
    always_ff @(posedge clk) begin
        if (r_state == FETCH && r_instr_ready && instr_valid) begin
            r_instr <= instr;
        end
    end

    // Sequencer FSM with all control outputs registered alongside the state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= FETCH;
            r_cnt          <= '0;
            r_zero         <= 1'b0;
            r_rd_op        <= 1'b0;
            r_wr_op        <= 1'b0;
            r_wb_op        <= 1'b0;
            r_br_op        <= 1'b0;
            r_halt_op      <= 1'b0;
            r_instr_ready  <= 1'b0;
            r_reg_dst      <= 1'b0;
            r_alu_src      <= 1'b0;
            r_mem_to_reg   <= 1'b0;
            r_mem_read     <= 1'b0;
            r_mem_write    <= 1'b0;
            r_reg_write    <= 1'b0;
            r_pc_en        <= 1'b0;
            r_branch_taken <= 1'b0;
            r_alu_op       <= '1;
            r_busy         <= 1'b0;
            r_halted       <= 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
            r_illegal_op   <= 1'b0;
`endif
        end else begin
            case (r_state)
                FETCH: begin
                    // Ready comes up one cycle after reset, then stays up until a handshake
                    if (r_instr_ready && instr_valid) begin
                        r_instr_ready <= 1'b0;
                        r_busy        <= 1'b1;
                        r_state       <= DECODE;
                    end else begin
                        r_instr_ready <= 1'b1;
                    end
                end

                DECODE: begin
                    if (w_trap) begin
                        r_state  <= HALT;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
                        r_illegal_op <= 1'b1;
`endif
                    end else begin
                        r_reg_dst    <= w_dec.reg_dst;
                        r_alu_src    <= w_dec.alu_src;
                        r_mem_to_reg <= w_dec.mem_to_reg;
                        r_alu_op     <= map_alu_op(w_dec.alu_op);
                        r_rd_op      <= w_dec.mem_read;
                        r_wr_op      <= w_dec.mem_write;
                        // An illegal op that is not trapped must never write a register
                        r_wb_op      <= w_dec.reg_write & ~w_dec.illegal;
                        r_br_op      <= w_dec.branch;
                        r_halt_op    <= w_dec.halt;
                        r_cnt        <= w_dec.mul ? MUL_LOAD : '0;
                        r_state      <= EXEC;
                    end
                end

                EXEC: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_zero <= zero_flag;
                        if (r_rd_op || r_wr_op) begin
                            r_mem_read  <= r_rd_op;
                            r_mem_write <= r_wr_op;
                            r_state     <= MEM;
                        end else begin
                            r_pc_en        <= ~r_halt_op;
                            r_reg_write    <= r_wb_op;
                            r_branch_taken <= r_br_op & zero_flag;
                            r_state        <= WB;
                        end
                    end
                end

                MEM: begin
                    // Unbounded wait: the memory owns the completion
                    if (mem_ack) begin
                        r_mem_read     <= 1'b0;
                        r_mem_write    <= 1'b0;
                        r_pc_en        <= ~r_halt_op;
                        r_reg_write    <= r_wb_op;
                        r_branch_taken <= r_br_op & r_zero;
                        r_state        <= WB;
                    end
                end

                WB: begin
                    // Single retire cycle; drop every per-instruction select afterwards
                    r_pc_en        <= 1'b0;
                    r_reg_write    <= 1'b0;
                    r_branch_taken <= 1'b0;
                    r_reg_dst      <= 1'b0;
                    r_alu_src      <= 1'b0;
                    r_mem_to_reg   <= 1'b0;
                    r_alu_op       <= '1;
                    r_busy         <= 1'b0;
                    if (r_halt_op) begin
                        r_halted <= 1'b1;
                        r_state  <= HALT;
                    end else begin
                        r_instr_ready <= 1'b1;
                        r_state       <= FETCH;
                    end
                end

                HALT: begin
                    r_state <= HALT;
                end

                default: begin
                    r_state <= FETCH;
                end
            endcase
        end
    end

    assign instr_ready  = r_instr_ready;
    assign reg_dst      = r_reg_dst;
    assign alu_src      = r_alu_src;
    assign mem_to_reg   = r_mem_to_reg;
    assign mem_read     = r_mem_read;
    assign mem_write    = r_mem_write;
    assign reg_write    = r_reg_write;
    assign pc_en        = r_pc_en;
    assign branch_taken = r_branch_taken;
    assign alu_op       = r_alu_op;
    assign busy         = r_busy;
    assign halted       = r_halted;
`ifdef CTRL_ILLEGAL_TRAP_EN
    assign illegal_op   = r_illegal_op;
`endif

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: scoreboard bench for ctrl_sequencer. Expected retire
// results are queued when an instruction is handed over and compared when
// the sequencer pulses pc_en.
`timescale 1ns/1ps
module tb_ctrl_sequencer;

    localparam int MC = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       instr_valid;
    logic [8:0] instr;
    logic       zero_flag;
    logic       mem_ack;
    logic       instr_ready, reg_dst, alu_src, mem_to_reg, mem_read, mem_write;
    logic       reg_write, pc_en, branch_taken, busy, halted;
    logic [3:0] alu_op;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic       illegal_op;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] op;
        logic       chk_op;
        logic       rw;
        logic       bt;
        logic       m2r;
        logic       mem;
        logic       mul;
        logic       retire;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    ctrl_sequencer #(.MCODEBITS(9), .OPWIDTH(4), .MUL_CYCLES(MC)) dut (
        .clk          (clk),
        .reset        (reset),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .zero_flag    (zero_flag),
        .mem_ack      (mem_ack),
        .reg_dst      (reg_dst),
        .alu_src      (alu_src),
        .mem_to_reg   (mem_to_reg),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .reg_write    (reg_write),
        .pc_en        (pc_en),
        .branch_taken (branch_taken),
        .alu_op       (alu_op),
        .busy         (busy),
        .halted       (halted)
`ifdef CTRL_ILLEGAL_TRAP_EN
        ,
        .illegal_op   (illegal_op)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference decode written from the instruction table
    function automatic exp_t exp_of(input logic [8:0] ins, input logic zf);
        exp_t e;
        logic [2:0] opc;
        logic [1:0] fn;
        opc = ins[8:6];
        fn  = ins[5:4];
        e.op = 4'h0; e.chk_op = 1'b1; e.rw = 1'b1; e.bt = 1'b0; e.m2r = 1'b0;
        e.mem = 1'b0; e.mul = 1'b0; e.retire = 1'b1;
        case (opc)
            3'd0: begin
                if (fn == 2'd0)      e.op = 4'd0;
                else if (fn == 2'd1) e.op = 4'd1;
                else begin e.rw = 1'b0; e.chk_op = 1'b0; end
            end
            3'd1: begin e.op = 4'hF; e.m2r = 1'b1; e.mem = 1'b1; end
            3'd2: begin e.rw = 1'b0; e.chk_op = 1'b0; e.mem = 1'b1; end
            3'd3: e.op = 4'd0;
            3'd4: begin e.rw = 1'b0; e.chk_op = 1'b0; e.bt = zf; end
            3'd5: begin
                if (fn == 2'd3) begin e.rw = 1'b0; e.chk_op = 1'b0; e.retire = 1'b0; end
                else e.op = 4'hF;
            end
            3'd6: e.op = 4'd2 + {2'b00, fn};
            default: begin
                if (fn == 2'd0)      e.op = 4'd6;
                else if (fn == 2'd1) e.op = 4'd7;
                else if (fn == 2'd2) begin e.op = 4'd8; e.mul = 1'b1; end
                else begin e.rw = 1'b0; e.chk_op = 1'b0; end
            end
        endcase
`ifdef CTRL_ILLEGAL_TRAP_EN
        if ((opc == 3'd0 && fn[1]) || (opc == 3'd7 && fn == 2'd3)) e.retire = 1'b0;
`endif
        return e;
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        while (!instr_ready && n < 20) begin
            tick();
            n++;
        end
        if (!instr_ready) check_eq("ready_timeout", instr_ready, 1);
    endtask

    // Hand over one instruction and run it to retire (or halt)
    task automatic run_instr(input logic [8:0] ins, input logic zf, input int w, input logic noise);
        exp_t e;
        int   n, mcyc, last, lat;
        e = exp_of(ins, zf);
        wait_ready();
        instr       = ins;
        zero_flag   = ~zf;
        instr_valid = 1'b1;
        if (e.retire) sbq.push_back(e);
        tick();
        instr_valid = 1'b0;
        last = 1 + (e.mul ? MC - 1 : 0);
        n    = 0;
        mcyc = 0;
        while (!pc_en && !halted && n < 40) begin
            zero_flag = (n == last) ? zf : ~zf;
            if (mem_read || mem_write) begin
                mcyc++;
                mem_ack = ((mcyc - 1) == w);
            end else begin
                mem_ack = noise;
            end
            tick();
            n++;
        end
        mem_ack = 1'b0;
        if (n >= 40) check_eq("retire_timeout", n, 0);
        if (e.retire) begin
            lat = 2 + (e.mul ? MC - 1 : 0) + (e.mem ? w + 1 : 0);
            check_eq("latency", n, lat);
            check_eq("mem_cycles", mcyc, e.mem ? w + 1 : 0);
        end
    endtask

    // Retire monitor: pops the scoreboard on each pc_en pulse
    always begin
        @(posedge clk);
        #2;
        if (reg_write) check_eq("rw_with_pc_en", pc_en, 1);
        if (pc_en) begin
            check_eq("sb_pending", sbq.size() != 0, 1);
            if (sbq.size() != 0) begin
                mon_e = sbq.pop_front();
                check_eq("wb_reg_write", reg_write, mon_e.rw);
                check_eq("wb_branch_taken", branch_taken, mon_e.bt);
                check_eq("wb_mem_to_reg", mem_to_reg, mon_e.m2r);
                if (mon_e.chk_op) check_eq("wb_alu_op", alu_op, mon_e.op);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    localparam int NT = 14;
    logic [8:0] t_ins   [NT];
    logic       t_zf    [NT];
    int         t_wait  [NT];
    logic       t_noise [NT];

    initial begin
        t_ins   = '{9'b011_00_0011, 9'b001_00_0001, 9'b010_00_0010, 9'b100_00_0000,
                    9'b100_00_0000, 9'b101_01_0000, 9'b110_00_0001, 9'b110_01_0001,
                    9'b110_10_0001, 9'b110_11_0001, 9'b111_00_0001, 9'b111_01_0001,
                    9'b111_10_0001, 9'b001_00_0111};
        t_zf    = '{0, 0, 1, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0};
        t_wait  = '{0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        t_noise = '{0, 1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0};

        reset = 1'b1; instr_valid = 1'b0; instr = '0; zero_flag = 1'b0; mem_ack = 1'b0;
        tick();
        tick();
        check_eq("rst_ready", instr_ready, 0);
        check_eq("rst_flags", {reg_dst, alu_src, mem_to_reg, mem_read, mem_write,
                               reg_write, pc_en, branch_taken, busy, halted}, 0);
        check_eq("rst_alu_op", alu_op, 4'hF);
`ifdef CTRL_ILLEGAL_TRAP_EN
        check_eq("rst_illegal_op", illegal_op, 0);
`endif
        reset = 1'b0;
        tick();
        check_eq("ready_after_rst", instr_ready, 1);

        // ADD then SUB back to back with valid held high: 4 cycles each
        instr = 9'b000_00_0101; instr_valid = 1'b1;
        sbq.push_back(exp_of(instr, 1'b0));
        tick();
        check_eq("c2_ready", instr_ready, 0);
        check_eq("c2_busy", busy, 1);
        check_eq("c2_alu_op", alu_op, 4'hF);
        tick();
        check_eq("c3_alu_op", alu_op, 4'd0);
        check_eq("c3_reg_write", reg_write, 0);
        tick();
        check_eq("c4_pc_en", pc_en, 1);
        check_eq("c4_reg_write", reg_write, 1);
        tick();
        check_eq("c5_ready", instr_ready, 1);
        check_eq("c5_pc_en", pc_en, 0);
        instr = 9'b000_01_0101;
        sbq.push_back(exp_of(instr, 1'b0));
        tick();
        tick();
        check_eq("c7_alu_op", alu_op, 4'd1);
        tick();
        check_eq("c8_pc_en", pc_en, 1);
        instr_valid = 1'b0;
        tick();
        check_eq("c9_ready", instr_ready, 1);

        for (int i = 0; i < NT; i++) begin
            run_instr(t_ins[i], t_zf[i], t_wait[i], t_noise[i]);
        end

`ifdef CTRL_ILLEGAL_TRAP_EN
        run_instr(9'b111_11_0000, 1'b0, 0, 1'b0);
        check_eq("trap_illegal_op", illegal_op, 1);
        check_eq("trap_halted", halted, 1);
        check_eq("trap_pc_en", pc_en, 0);
        reset = 1'b1;
        tick();
        check_eq("trap_clear", {illegal_op, halted}, 0);
        reset = 1'b0;
`else
        run_instr(9'b111_11_0000, 1'b0, 0, 1'b0);
        run_instr(9'b000_10_0000, 1'b0, 0, 1'b0);
        check_eq("nop_not_halted", halted, 0);
`endif

        // Reset in the middle of a store's memory wait
        wait_ready();
        instr = 9'b010_00_0001; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        tick();
        check_eq("st_mem_write", mem_write, 1);
        tick();
        check_eq("st_mem_hold", mem_write, 1);
        reset = 1'b1;
        tick();
        check_eq("midmem_mem_write", mem_write, 0);
        check_eq("midmem_alu_op", alu_op, 4'hF);
        check_eq("midmem_ready", instr_ready, 0);
        check_eq("midmem_busy", busy, 0);
        reset = 1'b0;
        tick();
        check_eq("midmem_ready_next", instr_ready, 1);

        // HALT is sticky and ignores a held valid
        run_instr(9'b101_11_0000, 1'b0, 0, 1'b0);
        check_eq("halt_halted", halted, 1);
        check_eq("halt_busy", busy, 0);
        instr = 9'b000_00_0001; instr_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq("halt_ready", instr_ready, 0);
            check_eq("halt_sticky", halted, 1);
        end
        instr_valid = 1'b0;

        check_eq("sb_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
